fust_scoreboard: RTL
====================

// Module: fust_scoreboard
// PURPOSE
// - Parametrised function-unit status table (FUST) and register result status for the dispatch/issue stages.
// - Serves both the scalar pipe (ALU/LD_ST/BRANCH, 2 sources) and the matrix pipe (LD_ST/GEMM, 3 sources) via parameters.
// - Tracks per-FU busy/dest/sources/producer tags; flags structural and WAW hazards at dispatch, RAW at issue, WAR at writeback.
// PARAMETERS
// - NUM_FU   4   number of function units (rows)
// - NUM_REG  32  architectural registers tracked
// - NUM_SRC  2   source operands per row (3 for matrix)
// - REG_W    5   register index width, $clog2(NUM_REG)
// - TAG_W    3   producer tag width, $clog2(NUM_FU+1); tag 0 = "value in regfile", tag k = FU k-1
// PORTS
// - CLK          in   1              clock, rising edge
// - nRST         in   1              async reset, active-low
// - flush        in   1              sync clear of all rows and result status
// - disp_valid   in   1              dispatch request
// - disp_fu      in   TAG_W          target FU index (0..NUM_FU-1)
// - disp_wen     in   1              instruction writes disp_rd
// - disp_rd      in   REG_W          destination register
// - disp_rs      in   NUM_SRC*REG_W  source registers, rs[i] at [i*REG_W +: REG_W]
// - disp_ready   out  1              dispatch accepted this cycle if disp_valid
// - fu_busy      out  NUM_FU         row occupied
// - fu_ready     out  NUM_FU         busy, not issued, all source tags 0
// - issue_fire   in   NUM_FU         operands read by FU (one-hot or zero)
// - wb_valid     in   1              writeback request
// - wb_fu        in   TAG_W          FU finishing
// - wb_ready     out  1              writeback accepted this cycle if wb_valid
// BEHAVIOUR
// - Reset/flush: all rows busy=0, issued=0, tags=0; rstat[*]=0; fu_busy=fu_ready=0. Outputs combinational from state.
// - disp_ready = !busy[disp_fu] && !(disp_wen && rd!=0 && rstat[rd]!=0) && disp_fu<NUM_FU.
// - Dispatch (valid&&ready): row<=busy=1, issued=0, rd, wen, rs[i], tag[i]=rstat[rs[i]] (0 for rs==0);
//   if disp_wen && rd!=0: rstat[rd]<=disp_fu+1. Effective next cycle; fu_ready can assert cycle after dispatch earliest.
// - issue_fire[k] on row with fu_ready[k]=0 is ignored; valid fire sets issued=1 (row stays busy).
// - wb_ready = 0 while any busy, un-issued row j!=wb_fu has rs[i]==rd(wb_fu) && tag[i]==0 && wen(wb_fu) (WAR); else 1.
// - Writeback (valid&&ready): row wb_fu busy<=0; rstat[rd]<=0 only if it still equals wb_fu+1;
//   every tag[i]==wb_fu+1 in every row <=0 (broadcast).
// - wb_valid for a non-busy FU: ignored, wb_ready=1, no state change.
// - Same-cycle dispatch+writeback: disp_ready uses pre-cycle state (freed row not reusable same cycle);
//   a dispatched source whose rstat equals accepted wb_fu+1 captures tag 0 (bypass); dispatch rstat write wins over wb clear for same rd.
// - Same-cycle issue_fire+writeback on same row: writeback wins (row cleared).
// - flush has priority over dispatch/issue/writeback; nRST low at any time returns to reset state immediately.
// - Register 0 never tracked: rstat[0] constant 0.
// CONFIGURATION
// - FUST_PERF_EN defined: adds outputs perf_disp_cnt, perf_stall_cnt, perf_war_cnt (32b each, reset 0, not cleared by flush, wrap at 2^32):
//   count accepted dispatches, cycles disp_valid&&!disp_ready, cycles wb_valid&&!wb_ready.
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset: nRST=0 mid-traffic -> fu_busy=0, fu_ready=0, disp_ready=1 for disp_fu=0, wb_ready=1.
// - RAW: dispatch FU0 rd=5; dispatch FU1 rs0=5 -> FU1 tag0=1, fu_ready[1]=0; wb FU0 -> fu_ready[1]=1 next cycle.
// - WAW/structural: FU0 busy writing r7; dispatch FU1 rd=7 -> disp_ready=0; dispatch FU0 any -> disp_ready=0.
// - WAR: FU2 dispatched rs1=9 (tag 0, not issued), FU0 rd=9 wb -> wb_ready=0 until issue_fire[2], then 1.
// - Bypass: wb FU0 (rd=3) same cycle as dispatch FU1 rs0=3 -> FU1 tag0=0, fu_ready[1]=1 next cycle.
// - Matrix config NUM_FU=2, NUM_SRC=3, NUM_REG=16: GEMM rs={1,2,3}, LD_ST rd=2 pending -> only tag1 nonzero; flush -> all clear.

Source files
------------

// File: rtl/fust_scoreboard.sv
// fust_scoreboard: function-unit status table plus register result status.
// Each row tracks one function unit: busy/issued flags, destination, the
// source registers and, per source, the tag of the FU still producing it
// (tag 0 = value already in the regfile, tag k = FU k-1). Hazards:
//   - structural / WAW  -> disp_ready low
//   - RAW               -> fu_ready low until every source tag clears
//   - WAR               -> wb_ready low while an un-issued reader still
//                          needs the old register value
// Optional feature: define FUST_PERF_EN to add three 32-bit performance
// counters (accepted dispatches, dispatch stall cycles, WAR stall cycles).
module fust_scoreboard #(
  parameter int NUM_FU  = 4,
  parameter int NUM_REG = 32,
  parameter int NUM_SRC = 2,
  parameter int REG_W   = 5,
  parameter int TAG_W   = 3
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic                       disp_valid,
  input  logic [TAG_W-1:0]           disp_fu,
  input  logic                       disp_wen,
  input  logic [REG_W-1:0]           disp_rd,
  input  logic [NUM_SRC*REG_W-1:0]   disp_rs,
  output logic                       disp_ready,
  output logic [NUM_FU-1:0]          fu_busy,
  output logic [NUM_FU-1:0]          fu_ready,
  input  logic [NUM_FU-1:0]          issue_fire,
  input  logic                       wb_valid,
  input  logic [TAG_W-1:0]           wb_fu,
  output logic                       wb_ready
`ifdef FUST_PERF_EN
  ,
  output logic [31:0]                perf_disp_cnt,
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_war_cnt
`endif
);

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  // Row state
  logic     [NUM_FU-1:0]              busy_q,   busy_d;
  logic     [NUM_FU-1:0]              issued_q, issued_d;
  logic     [NUM_FU-1:0]              wen_q,    wen_d;
  reg_idx_t [NUM_FU-1:0]              rd_q,     rd_d;
  reg_idx_t [NUM_FU-1:0][NUM_SRC-1:0] rs_q,     rs_d;
  tag_t     [NUM_FU-1:0][NUM_SRC-1:0] tag_q,    tag_d;

  // Register result status: producing FU tag per architectural register
  tag_t [NUM_REG-1:0] rstat_q, rstat_d;

  // Decoded request information
  logic                    disp_fu_ok;
  logic                    disp_busy;
  logic                    rd_pending;
  logic                    wb_busy;
  logic                    wb_wen;
  reg_idx_t                wb_rd;
  tag_t                    wb_tag;
  tag_t                    disp_tag_self;
  logic                    war_hit;
  logic                    disp_accept;
  logic                    wb_accept;
  logic [NUM_FU-1:0]       issue_ok;
  reg_idx_t [NUM_SRC-1:0]  disp_src;
  tag_t     [NUM_SRC-1:0]  disp_tag;

  // Register 0 and indices past NUM_REG always read as "in regfile".
  function automatic tag_t rstat_lookup(input tag_t [NUM_REG-1:0] tbl,
                                        input reg_idx_t          r);
    tag_t t;
    t = '0;
    for (int i = 1; i < NUM_REG; i++) begin
      if (r == reg_idx_t'(i)) t = tbl[i];
    end
    return t;
  endfunction

  // Decode the dispatch target and writeback source rows
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    disp_fu_ok    = (int'(disp_fu) < NUM_FU);
    disp_busy     = 1'b0;
    wb_busy       = 1'b0;
    wb_wen        = 1'b0;
    wb_rd         = '0;
    wb_tag        = wb_fu + tag_t'(1);
    disp_tag_self = disp_fu + tag_t'(1);
    for (int k = 0; k < NUM_FU; k++) begin
      if (disp_fu == tag_t'(k)) disp_busy = busy_q[k];
      if (wb_fu == tag_t'(k)) begin
        wb_busy = busy_q[k];
        wb_wen  = wen_q[k];
        wb_rd   = rd_q[k];
      end
    end
    rd_pending = disp_wen && (disp_rd != '0) &&
                 (rstat_lookup(rstat_q, disp_rd) != '0);
  end

  // WAR detection: an un-issued reader of wb_fu's destination with tag 0
  // still needs the old value, so the writeback must wait.
  always_comb begin
    war_hit = 1'b0;
    for (int j = 0; j < NUM_FU; j++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (busy_q[j] && !issued_q[j] && (wb_fu != tag_t'(j)) &&
            (rs_q[j][i] == wb_rd) && (tag_q[j][i] == '0))
          war_hit = 1'b1;
      end
    end
  end

  // Handshakes and per-row status outputs, all from pre-cycle state
  always_comb begin
    disp_ready  = disp_fu_ok && !disp_busy && !rd_pending;
    wb_ready    = !(wb_busy && wb_wen && war_hit);
    disp_accept = disp_valid && disp_ready;
    wb_accept   = wb_valid && wb_ready && wb_busy;
    fu_busy     = busy_q;
    for (int k = 0; k < NUM_FU; k++) begin
      fu_ready[k] = busy_q[k] && !issued_q[k] && (tag_q[k] == '0);
      issue_ok[k] = issue_fire[k] && fu_ready[k];
    end
  end

  // Source tag capture; a producer writing back this same cycle is
  // bypassed so the new row does not wait for a broadcast it missed.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      disp_src[i] = disp_rs[i*REG_W +: REG_W];
      disp_tag[i] = rstat_lookup(rstat_q, disp_src[i]);
      if (wb_accept && (disp_tag[i] == wb_tag)) disp_tag[i] = '0;
    end
  end

  // Next-state: issue, then writeback broadcast, then dispatch; flush last
  always_comb begin
    busy_d   = busy_q;
    issued_d = issued_q;
    wen_d    = wen_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    tag_d    = tag_q;
    rstat_d  = rstat_q;

    issued_d = issued_q | issue_ok;

    if (wb_accept) begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (wb_fu == tag_t'(k)) begin
          busy_d[k]   = 1'b0;
          issued_d[k] = 1'b0;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
          if (tag_q[k][i] == wb_tag) tag_d[k][i] = '0;
        end
      end
      for (int r = 1; r < NUM_REG; r++) begin
        if ((wb_rd == reg_idx_t'(r)) && (rstat_q[r] == wb_tag))
          rstat_d[r] = '0;
      end
    end

    if (disp_accept) begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (disp_fu == tag_t'(k)) begin
          busy_d[k]   = 1'b1;
          issued_d[k] = 1'b0;
          wen_d[k]    = disp_wen;
          rd_d[k]     = disp_rd;
          rs_d[k]     = disp_src;
          tag_d[k]    = disp_tag;
        end
      end
      // Applied after the writeback clear so a new producer of the same
      // register takes ownership.
      for (int r = 1; r < NUM_REG; r++) begin
        if (disp_wen && (disp_rd == reg_idx_t'(r)))
          rstat_d[r] = disp_tag_self;
      end
    end

    rstat_d[0] = '0;

    if (flush) begin
      busy_d   = '0;
      issued_d = '0;
      wen_d    = '0;
      rd_d     = '0;
      rs_d     = '0;
      tag_d    = '0;
      rstat_d  = '0;
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: the result-status table is reset along with the rows because a
    // stale producer tag would stall dispatch forever; it is a small
    // flop array, not a RAM, so a full reset is cheap and required.
    if (!nRST) begin
      busy_q   <= '0;
      issued_q <= '0;
      wen_q    <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      tag_q    <= '0;
      rstat_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge
      // values regardless of statement order.
      busy_q   <= busy_d;
      issued_q <= issued_d;
      wen_q    <= wen_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      tag_q    <= tag_d;
      rstat_q  <= rstat_d;
    end
  end

`ifdef FUST_PERF_EN
  logic [31:0] perf_disp_cnt_q,  perf_disp_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_war_cnt_q,   perf_war_cnt_d;

  // Event counters; they survive flush and wrap naturally
  always_comb begin
    perf_disp_cnt_d  = perf_disp_cnt_q  + 32'(disp_accept);
    perf_stall_cnt_d = perf_stall_cnt_q + 32'(disp_valid && !disp_ready);
    perf_war_cnt_d   = perf_war_cnt_q   + 32'(wb_valid && !wb_ready);
  end

  // Counter registers, cleared only by reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_disp_cnt_q  <= '0;
      perf_stall_cnt_q <= '0;
      perf_war_cnt_q   <= '0;
    end else begin
      perf_disp_cnt_q  <= perf_disp_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_war_cnt_q   <= perf_war_cnt_d;
    end
  end

  assign perf_disp_cnt  = perf_disp_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_war_cnt   = perf_war_cnt_q;
`endif

endmodule
